// File: rtl/bypass_ctrl.sv
// bypass_ctrl: operand bypass select and load-use hazard detection.
// Tracks destination tags of the EX and MM stages of a 5-stage pipe.
module bypass_ctrl #(
    parameter  int REG_NUM = 32,
    localparam int RW      = $clog2(REG_NUM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rd,
    input  logic          id_wen,
    input  logic          id_is_load,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic          id_use_rs1,
    input  logic          id_use_rs2,
    input  logic          pipe_stall,
    input  logic          flush,
    output logic [1:0]    fwd_sel_rs1,
    output logic [1:0]    fwd_sel_rs2,
    output logic          load_use_stall,
    output logic [15:0]   stall_count
);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rd;
        logic          is_load;
    } tag_t;

    localparam logic [1:0] SEL_FILE = 2'b00;
    localparam logic [1:0] SEL_EXP  = 2'b01;
    localparam logic [1:0] SEL_MMP  = 2'b10;
    localparam logic [1:0] SEL_MMM  = 2'b11;

    tag_t ex_tag;
    tag_t mm_tag;
    tag_t ex_next;

    logic flush_pending;
    logic eff_flush;

    logic m_ex1;
    logic m_mm1;
    logic m_ex2;
    logic m_mm2;
    logic hz_rs1;
    logic hz_rs2;

    // x0 never matches, so a tag naming it can never forward
    function automatic logic tag_match(
        input tag_t          t,
        input logic          en,
        input logic [RW-1:0] rs
    );
        return en && (rs != '0) && t.valid && (t.rd == rs);
    endfunction

    assign eff_flush = flush | flush_pending;

    assign m_ex1 = tag_match(ex_tag, id_use_rs1, id_rs1);
    assign m_mm1 = tag_match(mm_tag, id_use_rs1, id_rs1);
    assign m_ex2 = tag_match(ex_tag, id_use_rs2, id_rs2);
    assign m_mm2 = tag_match(mm_tag, id_use_rs2, id_rs2);

    assign hz_rs1 = m_ex1 & ex_tag.is_load;
    assign hz_rs2 = m_ex2 & ex_tag.is_load;

    assign load_use_stall = id_valid & (hz_rs1 | hz_rs2) & ~eff_flush;

    // rs1 select: youngest non-load producer first, then MM data or load
    always_comb begin
        fwd_sel_rs1 = SEL_FILE;
        if (m_ex1 && !ex_tag.is_load) begin
            fwd_sel_rs1 = SEL_EXP;
        end else if (m_mm1 && !mm_tag.is_load) begin
            fwd_sel_rs1 = SEL_MMP;
        end else if (m_mm1 && mm_tag.is_load) begin
            fwd_sel_rs1 = SEL_MMM;
        end
    end

    // rs2 select: same priority as rs1
    always_comb begin
        fwd_sel_rs2 = SEL_FILE;
        if (m_ex2 && !ex_tag.is_load) begin
            fwd_sel_rs2 = SEL_EXP;
        end else if (m_mm2 && !mm_tag.is_load) begin
            fwd_sel_rs2 = SEL_MMP;
        end else if (m_mm2 && mm_tag.is_load) begin
            fwd_sel_rs2 = SEL_MMM;
        end
    end

    // decode tag entering EX; bubble on stall, flush or no instruction
    always_comb begin
        ex_next.rd      = id_rd;
        ex_next.is_load = id_is_load;
        ex_next.valid   = id_valid & id_wen & (id_rd != '0)
                        & ~load_use_stall & ~eff_flush;
    end

    // tag pipeline advances only when the memory side is not stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_tag <= '0;
            mm_tag <= '0;
        end else if (!pipe_stall) begin
            mm_tag <= ex_tag;
            ex_tag <= ex_next;
        end
    end

    // remember a flush that arrived while frozen until the pipe moves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_pending <= 1'b0;
        end else if (pipe_stall) begin
            if (flush) begin
                flush_pending <= 1'b1;
            end
        end else begin
            flush_pending <= 1'b0;
        end
    end

    // saturating count of load-use stall cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (load_use_stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_bypass_ctrl.sv
// tb_bypass_ctrl: scoreboard bench for bypass_ctrl.
// Expected outputs are queued per cycle and compared per scenario.
module tb_bypass_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rd;
    logic        id_wen;
    logic        id_is_load;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        pipe_stall;
    logic        flush;
    logic [1:0]  fwd_sel_rs1;
    logic [1:0]  fwd_sel_rs2;
    logic        load_use_stall;
    logic [15:0] stall_count;

    typedef struct {
        string       name;
        logic [1:0]  f1;
        logic        c1;
        logic [1:0]  f2;
        logic        c2;
        logic        lus;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic        lus;
        logic [15:0] cnt;
    } obs_t;

    exp_t sb[$];
    obs_t ob[$];

    int          n_run;
    int          n_fail;
    logic [15:0] exp_cnt;

    bypass_ctrl #(.REG_NUM(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rd          (id_rd),
        .id_wen         (id_wen),
        .id_is_load     (id_is_load),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .pipe_stall     (pipe_stall),
        .flush          (flush),
        .fwd_sel_rs1    (fwd_sel_rs1),
        .fwd_sel_rs2    (fwd_sel_rs2),
        .load_use_stall (load_use_stall),
        .stall_count    (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drv(
        input logic       v,
        input logic [4:0] rd,
        input logic       wen,
        input logic       ld,
        input logic [4:0] rs1,
        input logic       u1,
        input logic [4:0] rs2,
        input logic       u2,
        input logic       ps,
        input logic       fl
    );
        id_valid   = v;
        id_rd      = rd;
        id_wen     = wen;
        id_is_load = ld;
        id_rs1     = rs1;
        id_use_rs1 = u1;
        id_rs2     = rs2;
        id_use_rs2 = u2;
        pipe_stall = ps;
        flush      = fl;
    endtask

    task automatic put(
        input string       nm,
        input logic [1:0]  f1,
        input logic        c1,
        input logic [1:0]  f2,
        input logic        c2,
        input logic        lus,
        input logic [15:0] cnt
    );
        exp_t e;
        e.name = nm;
        e.f1   = f1;
        e.c1   = c1;
        e.f2   = f2;
        e.c2   = c2;
        e.lus  = lus;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    task automatic sample();
        obs_t o;
        #1;
        o.f1  = fwd_sel_rs1;
        o.f2  = fwd_sel_rs2;
        o.lus = load_use_stall;
        o.cnt = stall_count;
        ob.push_back(o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        obs_t o;
        rst = 1'b1;
        @(negedge clk);
        drv(1, 7, 1, 1, 5, 1, 7, 1, 0, 0);
        put("rst_idle", 0, 1, 0, 1, 0, 0);
        sample();
        @(negedge clk);
        drv(1, 7, 1, 1, 7, 1, 7, 1, 0, 0);
        put("rst_hold", 0, 1, 0, 1, 0, 0);
        sample();
        @(negedge clk);
        rst = 1'b0;
        drv(1, 0, 0, 0, 7, 1, 7, 1, 0, 0);
        put("rst_first", 0, 1, 0, 1, 0, 0);
        sample();
        exp_cnt = 16'd0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = ob.pop_front();
            if (e.c1) begin
                n_run++;
                if (o.f1 !== e.f1) begin
                    n_fail++;
                    $display("FAIL %s fwd_sel_rs1 got %b want %b",
                             e.name, o.f1, e.f1);
                end
            end
            if (e.c2) begin
                n_run++;
                if (o.f2 !== e.f2) begin
                    n_fail++;
                    $display("FAIL %s fwd_sel_rs2 got %b want %b",
                             e.name, o.f2, e.f2);
                end
            end
            n_run++;
            if (o.lus !== e.lus) begin
                n_fail++;
                $display("FAIL %s load_use_stall got %b want %b",
                         e.name, o.lus, e.lus);
            end
            n_run++;
            if (o.cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s stall_count got %0d want %0d",
                         e.name, o.cnt, e.cnt);
            end
        end
    endtask

    task automatic test_alu_fwd();
        exp_t e;
        obs_t o;
        idle(2);
        @(negedge clk);
        drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        put("alu_prod", 0, 1, 0, 1, 0, exp_cnt);
        sample();
        @(negedge clk);
        drv(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        put("alu_ex", 2'b01, 1, 0, 1, 0, exp_cnt);
        sample();
        @(negedge clk);
        drv(1, 0, 0, 0, 5, 1, 5, 1, 0, 0);
        put("alu_mm", 2'b10, 1, 2'b10, 1, 0, exp_cnt);
        sample();
        @(negedge clk);
        drv(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        put("alu_gone", 0, 1, 0, 1, 0, exp_cnt);
        sample();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = ob.pop_front();
            if (e.c1) begin
                n_run++;
                if (o.f1 !== e.f1) begin
                    n_fail++;
                    $display("FAIL %s fwd_sel_rs1 got %b want %b",
                             e.name, o.f1, e.f1);
                end
            end
            if (e.c2) begin
                n_run++;
                if (o.f2 !== e.f2) begin
                    n_fail++;
                    $display("FAIL %s fwd_sel_rs2 got %b want %b",
                             e.name, o.f2, e.f2);
                end
            end
            n_run++;
            if (o.lus !== e.lus) begin
                n_fail++;
                $display("FAIL %s load_use_stall got %b want %b",
                         e.name, o.lus, e.lus);
            end
            n_run++;
            if (o.cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s stall_count got %0d want %0d",
                         e.name, o.cnt, e.cnt);
            end
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        obs_t o;
        idle(2);
        @(negedge clk);
        drv(1, 7, 1, 1, 0, 0, 0, 0, 0, 0);
        put("ld_prod", 0, 1, 0, 1, 0, exp_cnt);
        sample();
        @(negedge clk);
        drv(1, 0, 0, 0, 0, 0, 7, 1, 0, 0);
        put("ld_stall", 0, 1, 0, 0, 1, exp_cnt);
        sample();
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        drv(1, 0, 0, 0, 0, 0, 7, 1, 0, 0);
        put("ld_fwd", 0, 1, 2'b11, 1, 0, exp_cnt);
        sample();
        @(negedge clk);
        drv(1, 0, 0, 0, 7, 1, 7, 1, 0, 0);
        put("ld_drained", 0, 1, 0, 1, 0, exp_cnt);
        sample();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = ob.pop_front();
            if (e.c1) begin
                n_run++;
                if (o.f1 !== e.f1) begin
                    n_fail++;
                    $display("FAIL %s fwd_sel_rs1 got %b want %b",
                             e.name, o.f1, e.f1);
                end
            end
            if (e.c2) begin
                n_run++;
                if (o.f2 !== e.f2) begin
                    n_fail++;
                    $display("FAIL %s fwd_sel_rs2 got %b want %b",
                             e.name, o.f2, e.f2);
                end
            end
            n_run++;
            if (o.lus !== e.lus) begin
                n_fail++;
                $display("FAIL %s load_use_stall got %b want %b",
                         e.name, o.lus, e.lus);
            end
            n_run++;
            if (o.cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s stall_count got %0d want %0d",
                         e.name, o.cnt, e.cnt);
            end
        end
    endtask

    task automatic test_ex_priority();
        exp_t e;
        obs_t o;
        idle(2);
        @(negedge clk);
        drv(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        put("pri_p1", 0, 1, 0, 1, 0, exp_cnt);
        sample();
        @(negedge clk);
        drv(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        put("pri_p2", 0, 1, 0, 1, 0, exp_cnt);
        sample();
        @(negedge clk);
        drv(1, 0, 0, 0, 3, 1, 3, 0, 0, 0);
        put("pri_ex_wins", 2'b01, 1, 0, 1, 0, exp_cnt);
        sample();
        @(negedge clk);
        drv(1, 0, 0, 0, 3, 1, 3, 1, 0, 0);
        put("pri_mm_left", 2'b10, 1, 2'b10, 1, 0, exp_cnt);
        sample();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = ob.pop_front();
            if (e.c1) begin
                n_run++;
                if (o.f1 !== e.f1) begin
                    n_fail++;
                    $display("FAIL %s fwd_sel_rs1 got %b want %b",
                             e.name, o.f1, e.f1);
                end
            end
            if (e.c2) begin
                n_run++;
                if (o.f2 !== e.f2) begin
                    n_fail++;
                    $display("FAIL %s fwd_sel_rs2 got %b want %b",
                             e.name, o.f2, e.f2);
                end
            end
            n_run++;
            if (o.lus !== e.lus) begin
                n_fail++;
                $display("FAIL %s load_use_stall got %b want %b",
                         e.name, o.lus, e.lus);
            end
            n_run++;
            if (o.cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s stall_count got %0d want %0d",
                         e.name, o.cnt, e.cnt);
            end
        end
    endtask

    task automatic test_x0();
        exp_t e;
        obs_t o;
        idle(2);
        @(negedge clk);
        drv(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        put("x0_prod", 0, 1, 0, 1, 0, exp_cnt);
        sample();
        @(negedge clk);
        drv(1, 0, 1, 1, 0, 1, 0, 1, 0, 0);
        put("x0_ex", 0, 1, 0, 1, 0, exp_cnt);
        sample();
        @(negedge clk);
        drv(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        put("x0_load", 0, 1, 0, 1, 0, exp_cnt);
        sample();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = ob.pop_front();
            if (e.c1) begin
                n_run++;
                if (o.f1 !== e.f1) begin
                    n_fail++;
                    $display("FAIL %s fwd_sel_rs1 got %b want %b",
                             e.name, o.f1, e.f1);
                end
            end
            if (e.c2) begin
                n_run++;
                if (o.f2 !== e.f2) begin
                    n_fail++;
                    $display("FAIL %s fwd_sel_rs2 got %b want %b",
                             e.name, o.f2, e.f2);
                end
            end
            n_run++;
            if (o.lus !== e.lus) begin
                n_fail++;
                $display("FAIL %s load_use_stall got %b want %b",
                         e.name, o.lus, e.lus);
            end
            n_run++;
            if (o.cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s stall_count got %0d want %0d",
                         e.name, o.cnt, e.cnt);
            end
        end
    endtask

    task automatic test_stall_hold();
        exp_t e;
        obs_t o;
        idle(2);
        @(negedge clk);
        drv(1, 7, 1, 1, 0, 0, 0, 0, 0, 0);
        put("hold_prod", 0, 1, 0, 1, 0, exp_cnt);
        sample();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drv(1, 0, 0, 0, 0, 0, 7, 1, 1, 0);
            put("hold_ps", 0, 1, 0, 0, 1, exp_cnt);
            sample();
            exp_cnt = exp_cnt + 16'd1;
        end
        @(negedge clk);
        drv(1, 0, 0, 0, 0, 0, 7, 1, 0, 0);
        put("hold_release", 0, 1, 0, 0, 1, exp_cnt);
        sample();
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        drv(1, 0, 0, 0, 0, 0, 7, 1, 0, 0);
        put("hold_fwd", 0, 1, 2'b11, 1, 0, exp_cnt);
        sample();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = ob.pop_front();
            if (e.c1) begin
                n_run++;
                if (o.f1 !== e.f1) begin
                    n_fail++;
                    $display("FAIL %s fwd_sel_rs1 got %b want %b",
                             e.name, o.f1, e.f1);
                end
            end
            if (e.c2) begin
                n_run++;
                if (o.f2 !== e.f2) begin
                    n_fail++;
                    $display("FAIL %s fwd_sel_rs2 got %b want %b",
                             e.name, o.f2, e.f2);
                end
            end
            n_run++;
            if (o.lus !== e.lus) begin
                n_fail++;
                $display("FAIL %s load_use_stall got %b want %b",
                         e.name, o.lus, e.lus);
            end
            n_run++;
            if (o.cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s stall_count got %0d want %0d",
                         e.name, o.cnt, e.cnt);
            end
        end
    endtask

    task automatic test_flush_stall();
        exp_t e;
        obs_t o;
        idle(2);
        @(negedge clk);
        drv(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        put("fl_prod", 0, 1, 0, 1, 0, exp_cnt);
        sample();
        @(negedge clk);
        drv(1, 10, 1, 0, 9, 1, 0, 0, 1, 1);
        put("fl_pulse", 2'b01, 1, 0, 1, 0, exp_cnt);
        sample();
        @(negedge clk);
        drv(1, 10, 1, 0, 9, 1, 0, 0, 1, 0);
        put("fl_frozen", 2'b01, 1, 0, 1, 0, exp_cnt);
        sample();
        @(negedge clk);
        drv(1, 10, 1, 0, 9, 1, 0, 0, 0, 0);
        put("fl_apply", 2'b01, 1, 0, 1, 0, exp_cnt);
        sample();
        @(negedge clk);
        drv(1, 0, 0, 0, 10, 1, 9, 1, 0, 0);
        put("fl_killed", 0, 1, 2'b10, 1, 0, exp_cnt);
        sample();
        @(negedge clk);
        drv(1, 7, 1, 1, 0, 0, 0, 0, 0, 0);
        put("fl_ld_prod", 0, 1, 0, 1, 0, exp_cnt);
        sample();
        @(negedge clk);
        drv(1, 0, 0, 0, 0, 0, 7, 1, 0, 1);
        put("fl_no_stall", 0, 1, 0, 0, 0, exp_cnt);
        sample();
        @(negedge clk);
        drv(1, 0, 0, 0, 0, 0, 7, 1, 0, 0);
        put("fl_ld_mm", 0, 1, 2'b11, 1, 0, exp_cnt);
        sample();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = ob.pop_front();
            if (e.c1) begin
                n_run++;
                if (o.f1 !== e.f1) begin
                    n_fail++;
                    $display("FAIL %s fwd_sel_rs1 got %b want %b",
                             e.name, o.f1, e.f1);
                end
            end
            if (e.c2) begin
                n_run++;
                if (o.f2 !== e.f2) begin
                    n_fail++;
                    $display("FAIL %s fwd_sel_rs2 got %b want %b",
                             e.name, o.f2, e.f2);
                end
            end
            n_run++;
            if (o.lus !== e.lus) begin
                n_fail++;
                $display("FAIL %s load_use_stall got %b want %b",
                         e.name, o.lus, e.lus);
            end
            n_run++;
            if (o.cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s stall_count got %0d want %0d",
                         e.name, o.cnt, e.cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        obs_t o;
        idle(2);
        @(negedge clk);
        drv(1, 7, 1, 1, 0, 0, 0, 0, 0, 0);
        put("ar_prod", 0, 1, 0, 1, 0, exp_cnt);
        sample();
        @(negedge clk);
        drv(1, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        put("ar_pre", 0, 0, 0, 1, 1, exp_cnt);
        sample();
        #1;
        rst = 1'b1;
        put("ar_async", 0, 1, 0, 1, 0, 16'd0);
        sample();
        exp_cnt = 16'd0;
        @(negedge clk);
        rst = 1'b0;
        drv(1, 0, 0, 0, 7, 1, 7, 1, 0, 0);
        put("ar_after", 0, 1, 0, 1, 0, exp_cnt);
        sample();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = ob.pop_front();
            if (e.c1) begin
                n_run++;
                if (o.f1 !== e.f1) begin
                    n_fail++;
                    $display("FAIL %s fwd_sel_rs1 got %b want %b",
                             e.name, o.f1, e.f1);
                end
            end
            if (e.c2) begin
                n_run++;
                if (o.f2 !== e.f2) begin
                    n_fail++;
                    $display("FAIL %s fwd_sel_rs2 got %b want %b",
                             e.name, o.f2, e.f2);
                end
            end
            n_run++;
            if (o.lus !== e.lus) begin
                n_fail++;
                $display("FAIL %s load_use_stall got %b want %b",
                         e.name, o.lus, e.lus);
            end
            n_run++;
            if (o.cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL %s stall_count got %0d want %0d",
                         e.name, o.cnt, e.cnt);
            end
        end
    endtask

    initial begin
        n_run   = 0;
        n_fail  = 0;
        exp_cnt = 16'd0;
        rst     = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_ex_priority();
        test_x0();
        test_stall_hold();
        test_flush_stall();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
